// File: rtl/hazard_detect_unit.sv
// ID-stage hazard controller: load-use and mult/div occupancy stalls, taken-branch
// IF/ID flush, mult/div busy-window tracking and stall/flush statistics.
module hazard_detect_unit #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic [4:0]       rt_ex,
  input  logic             readmem_ex,
  input  logic             branch_taken,
  input  logic             md_start_id,
  input  logic             md_use_id,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  localparam logic [3:0] LAT_M1 = 4'(MD_LATENCY - 1);

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             md_busy_q;
  logic             md_done_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu, mdh, stall, flush;

  always_comb begin
    lu    = readmem_ex && (rt_ex != 5'd0) &&
            ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
    mdh   = md_busy_q && (md_start_id || md_use_id);
    stall = lu || mdh;
    // A branch resolved in a held ID stage is re-seen once the stall clears.
    flush = branch_taken && !stall;
  end

  always_comb begin
    if (rst) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
    end else begin
      pc_write    = !stall;
      ifid_write  = !stall;
      idex_bubble = stall;
      ifid_flush  = flush;
    end
  end

  // Busy window: issue edge loads LATENCY-1, so BUSY lasts exactly MD_LATENCY
  // cycles and md_done marks the cycle whose count has reached zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          md_done_q <= 1'b0;
          if (md_start_id && !stall) begin
            state_q   <= BUSY;
            cnt_q     <= LAT_M1;
            md_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q     <= cnt_q - 4'd1;
            md_done_q <= (cnt_q == 4'd1);
          end else begin
            state_q   <= IDLE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          md_busy_q <= 1'b0;
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + (stall ? CNT_W'(1) : '0);
    flush_cnt_d = flush_cnt_q + (flush ? CNT_W'(1) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign md_busy   = md_busy_q;
  assign md_done   = md_done_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Bench for hazard_detect_unit (MD_LATENCY=4, CNT_W=4): directed scenarios plus
// randomized traffic checked against a cycle-count reference model.
module tb_hazard_detect_unit;

  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs_id, rt_id, rt_ex;
  logic          uses_rt_id, readmem_ex, branch_taken, md_start_id, md_use_id;
  logic          pc_write, ifid_write, idex_bubble, ifid_flush, md_busy, md_done;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int unsigned vectors = 0;
  int unsigned errs    = 0;

  // Reference model: cycles of remaining occupancy and raw event totals.
  int unsigned busy_left   = 0;
  int unsigned stall_total = 0;
  int unsigned flush_total = 0;

  hazard_detect_unit #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .rt_ex(rt_ex), .readmem_ex(readmem_ex), .branch_taken(branch_taken),
    .md_start_id(md_start_id), .md_use_id(md_use_id), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic m_stall();
    logic lu;
    lu = readmem_ex && rt_ex != 0 && (rt_ex == rs_id || (uses_rt_id && rt_ex == rt_id));
    return lu || (busy_left > 0 && (md_start_id || md_use_id));
  endfunction

  function automatic logic [13:0] expv();
    logic st, fl;
    st = m_stall();
    fl = branch_taken && !st;
    if (rst) begin st = 1'b0; fl = 1'b0; end
    return {!st, !st, st, fl, busy_left > 0, busy_left == 1,
            4'(stall_total), 4'(flush_total)};
  endfunction

  function automatic logic [13:0] obs();
    return {pc_write, ifid_write, idex_bubble, ifid_flush, md_busy, md_done,
            stall_cnt, flush_cnt};
  endfunction

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] rtx, input logic rm,
                       input logic br, input logic ms, input logic mu);
    rst = r; rs_id = rs; rt_id = rt; uses_rt_id = urt; rt_ex = rtx;
    readmem_ex = rm; branch_taken = br; md_start_id = ms; md_use_id = mu;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Advance one clock and step the model with the inputs seen at that edge.
  task automatic tick();
    logic st, fl;
    @(posedge clk);
    st = m_stall();
    fl = branch_taken && !st;
    if (rst) begin
      busy_left = 0; stall_total = 0; flush_total = 0;
    end else begin
      stall_total += st ? 1 : 0;
      flush_total += fl ? 1 : 0;
      if (busy_left > 0) busy_left--;
      else if (md_start_id && !st) busy_left = LAT;
    end
    #1;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'b1,
            1'b1, 1'($urandom), 1'($urandom));
      if (i > 0) begin
        @(negedge clk); vectors++;
        if (obs() !== expv() || obs() !== 14'b1100_00_0000_0000) begin
          $display("FAIL reset[%0d]: got %b exp %b", i, obs(), expv()); errs++;
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b0, 5'd8, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); vectors++;
    if (obs() !== expv() || pc_write !== 1'b0 || idex_bubble !== 1'b1) begin
      $display("FAIL load_use stall: got %b exp %b", obs(), expv()); errs++;
    end
    tick();
    drive(1'b0, 5'd8, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); vectors++;
    if (obs() !== expv() || pc_write !== 1'b1 || stall_cnt !== 4'd1) begin
      $display("FAIL load_use release: got %b exp %b", obs(), expv()); errs++;
    end
    tick();
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); vectors++;
    if (obs() !== expv() || pc_write !== 1'b1) begin
      $display("FAIL zero_reg: got %b exp %b", obs(), expv()); errs++;
    end
    tick();
    drive(1'b0, 5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); vectors++;
    if (obs() !== expv() || idex_bubble !== 1'b0) begin
      $display("FAIL rt_unused: got %b exp %b", obs(), expv()); errs++;
    end
    tick();
    drive(1'b0, 5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); vectors++;
    if (obs() !== expv() || idex_bubble !== 1'b1) begin
      $display("FAIL rt_used: got %b exp %b", obs(), expv()); errs++;
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    drive(1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); vectors++;
    if (obs() !== expv() || ifid_flush !== 1'b1) begin
      $display("FAIL branch_flush: got %b exp %b", obs(), expv()); errs++;
    end
    tick();
    drive(1'b0, 5'd6, 5'd2, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); vectors++;
    if (obs() !== expv() || ifid_flush !== 1'b0 || flush_cnt !== 4'd1) begin
      $display("FAIL branch_vs_lu: got %b exp %b", obs(), expv()); errs++;
    end
    tick();
    drive(1'b0, 5'd6, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); vectors++;
    if (obs() !== expv() || ifid_flush !== 1'b1 || stall_cnt !== 4'd1) begin
      $display("FAIL branch_deferred: got %b exp %b", obs(), expv()); errs++;
    end
    tick(); idle_in();
    @(negedge clk); vectors++;
    if (flush_cnt !== 4'd2) begin
      $display("FAIL flush_cnt: got %0d exp 2", flush_cnt); errs++;
    end
  endtask

  task automatic test_md_window();
    // {md_busy, md_done, pc_write} expected at t .. t+5, mflo from t+2 onward.
    logic [2:0] want [6] = '{3'b001, 3'b101, 3'b100, 3'b100, 3'b110, 3'b001};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle_in();
      md_start_id = (c == 0);
      md_use_id   = (c >= 2);
      @(negedge clk); vectors++;
      if (obs() !== expv() || {md_busy, md_done, pc_write} !== want[c]) begin
        $display("FAIL md_window t+%0d: got %b exp %b", c, obs(), expv()); errs++;
      end
      tick();
    end
    idle_in();
    @(negedge clk); vectors++;
    if (stall_cnt !== 4'd3) begin
      $display("FAIL md_stall_cnt: got %0d exp 3", stall_cnt); errs++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    idle_in(); md_start_id = 1'b1; md_use_id = 1'b1;
    for (int c = 0; c < 3 * (LAT + 1); c++) begin
      @(negedge clk); vectors++;
      if (obs() !== expv() || md_busy !== 1'((c % (LAT + 1)) != 0)) begin
        $display("FAIL back_to_back c%0d: got %b exp %b", c, obs(), expv()); errs++;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    idle_in(); md_start_id = 1'b1; tick();
    idle_in(); md_use_id = 1'b1; tick();
    rst = 1'b1;
    @(negedge clk); vectors++;
    if (obs() !== expv() || pc_write !== 1'b1 || md_busy !== 1'b1) begin
      $display("FAIL rst_mid_busy: got %b exp %b", obs(), expv()); errs++;
    end
    tick(); rst = 1'b0;
    @(negedge clk); vectors++;
    if (obs() !== expv() || md_busy !== 1'b0 || stall_cnt !== 4'd0 || pc_write !== 1'b1) begin
      $display("FAIL after_rst_busy: got %b exp %b", obs(), expv()); errs++;
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b0, 5'd7, 5'd2, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) tick();
    idle_in();
    @(negedge clk); vectors++;
    if (obs() !== expv() || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      $display("FAIL stall_wrap: got %b exp %b", obs(), expv()); errs++;
    end
    branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    idle_in();
    @(negedge clk); vectors++;
    if (obs() !== expv() || flush_cnt !== 4'd1) begin
      $display("FAIL flush_wrap: got %b exp %b", obs(), expv()); errs++;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 59) == 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0));
      @(negedge clk); vectors++;
      if (obs() !== expv()) begin
        $display("FAIL random[%0d]: got %b exp %b", i, obs(), expv()); errs++;
      end
      tick();
    end
  endtask

  initial begin
    idle_in();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_md_window();
    test_back_to_back();
    test_reset_mid_busy();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
